// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and RAM bus bundle for the memory port arbiter
//
// Groups the three-requester handshake and the single-port RAM signals.
//   req       [2:0]      per-requester access request (level, held until ack)
//   we_in     [2:0]      per-requester write enable
//   addr_in   [3*AW-1:0] packed addresses, requester i at [i*AW +: AW]
//   wdata_in  [3*DW-1:0] packed write data, requester i at [i*DW +: DW]
//   ack       [2:0]      one-hot, one-cycle completion pulse
//   rdata     [DW-1:0]   read data, valid while ack is high
//   grant     [2:0]      one-hot owner of the access in flight
//   busy                 access in flight
//   mem_en, mem_we, mem_addr, mem_wdata  RAM command
//   mem_rdata            RAM read data, valid one cycle after mem_en
// slave  = arbiter side, master = requesters plus RAM side.

interface mem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [2:0]      req;
  logic [2:0]      we_in;
  logic [3*AW-1:0] addr_in;
  logic [3*DW-1:0] wdata_in;
  logic [2:0]      ack;
  logic [DW-1:0]   rdata;
  logic [2:0]      grant;
  logic            busy;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  req, we_in, addr_in, wdata_in, mem_rdata,
    output ack, rdata, grant, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we_in, addr_in, wdata_in, mem_rdata,
    input  ack, rdata, grant, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter and access sequencer for a single-port RAM
//
// Three requesters (0 = fetch, 1 = load/store, 2 = host/debug) share one
// synchronous RAM. Each access takes three cycles: IDLE (arbitrate and latch
// the winner's command), ACCESS (mem_en high), RESP (ack pulse, read data).
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset, aborts any access in flight
//   bus   mem_port_arbiter_if.slave: requester handshake and RAM command/data

module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] rr_ptr;   // index of the requester served last
  logic [1:0] win_q;    // index of the requester owning the current access
  logic [1:0] win;
  logic       win_vld;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    onehot3 = 3'b001 << idx;
  endfunction

  // Search starts just after the last served requester, so the one served
  // last is considered only when nobody else is asking.
  always_comb begin
    win = 2'd0;
    case (rr_ptr)
      2'd0: begin
        if (bus.req[1])      win = 2'd1;
        else if (bus.req[2]) win = 2'd2;
        else                 win = 2'd0;
      end
      2'd1: begin
        if (bus.req[2])      win = 2'd2;
        else if (bus.req[0]) win = 2'd0;
        else                 win = 2'd1;
      end
      default: begin
        if (bus.req[0])      win = 2'd0;
        else if (bus.req[1]) win = 2'd1;
        else                 win = 2'd2;
      end
    endcase
  end

  assign win_vld = |bus.req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= 2'd2;
      win_q         <= 2'd0;
      bus.ack       <= 3'b000;
      bus.grant     <= 3'b000;
      bus.busy      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.ack <= 3'b000;
          if (win_vld) begin
            // The command is captured here; requester fields are ignored
            // for the rest of the access.
            bus.grant     <= onehot3(win);
            win_q         <= win;
            bus.mem_addr  <= bus.addr_in[win*AW +: AW];
            bus.mem_wdata <= bus.wdata_in[win*DW +: DW];
            bus.mem_we    <= bus.we_in[win];
            bus.mem_en    <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= ACCESS;
          end else begin
            bus.grant  <= 3'b000;
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.busy   <= 1'b0;
          end
        end
        ACCESS: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.ack    <= onehot3(win_q);
          state      <= RESP;
        end
        RESP: begin
          bus.ack   <= 3'b000;
          bus.grant <= 3'b000;
          bus.busy  <= 1'b0;
          rr_ptr    <= win_q;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The RAM output register already holds the read result during RESP, so
  // it is steered straight through rather than delayed another cycle.
  assign bus.rdata = (state == RESP) ? bus.mem_rdata : {DW{1'b0}};

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter and access sequencer for the 8-bit CPU's single-port synchronous RAM.
- Three requesters share the port: 0 = instruction fetch, 1 = data load/store, 2 = host loader/debug.
- Each requester uses a req/ack handshake. The block serialises accesses, drives the RAM, and returns read data with a one-cycle ack pulse.

Parameters:
- AW, 8, address width in bits.
- DW, 8, data width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  3  per-requester access request; level, held until ack.
- we_in  in  3  per-requester write enable; 1 = write, 0 = read.
- addr_in  in  3*AW  packed addresses; requester i uses bits [i*AW +: AW].
- wdata_in  in  3*DW  packed write data; requester i uses bits [i*DW +: DW].
- ack  out  3  one-hot, one-cycle completion pulse to the served requester.
- rdata  out  DW  read data, valid in the cycle ack is high.
- grant  out  3  one-hot owner of the current access.
- busy  out  1  high while an access is in flight (ACCESS or RESP).
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid one cycle after mem_en.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, rr_ptr = 2.
  - ack, grant, busy, mem_en, mem_we = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - Any in-flight access is aborted and no ack is issued for it.
- State machine, three states, one access per 3 cycles at most:
  - IDLE:
    - If req != 0 at edge E, choose winner w by round-robin.
    - Search order is (rr_ptr+1)%3, (rr_ptr+2)%3, rr_ptr; first set req bit wins.
    - At E, register grant = onehot(w) and latch mem_addr, mem_we, mem_wdata from requester w.
    - At E, set mem_en = 1, busy = 1, go to ACCESS.
    - If req == 0, stay in IDLE with all outputs 0 except mem_addr and mem_wdata, which hold their last values.
  - ACCESS (cycle after E):
    - mem_en high for exactly this cycle; the RAM captures a write or launches a read on the next edge.
    - At the next edge: mem_en = 0, mem_we = 0, go to RESP.
  - RESP:
    - ack = onehot(w) for exactly this cycle; rdata = mem_rdata, registered from the RAM output at entry.
    - For writes, rdata = mem_rdata (don't-care, but deterministic).
    - At the next edge: ack = 0, grant = 0, busy = 0, rr_ptr = w, go to IDLE.
- Latency:
  - req sampled at edge E.
  - mem_en high in cycle E+1.
  - ack and rdata in cycle E+2.
  - Earliest next grant is sampled at edge E+3.
- Requester contract:
  - Drop req, or present a new request, at the edge that ends the ack cycle.
  - Because IDLE samples only after RESP, no double issue occurs.
- Request inputs are sampled only in IDLE. Changes to addr, we or wdata during ACCESS/RESP have no effect.
- If req is withdrawn before ack, the access still completes and ack still pulses. There is no cancel.
- Fairness:
  - With continuous requests, each requester waits at most 2 other accesses (6 cycles) plus its own 3.
  - Simultaneous requests are resolved purely by rr_ptr; there is no static priority.
- Invariants:
  - grant, ack and mem_en never have more than one bit set.
  - ack is high only in RESP.

Test Plan:
1. Single read. RAM preloaded mem[0x10]=0xA5; req=001, we_in=000, addr0=0x10.
   -> mem_en at E+1 with mem_addr=0x10; ack=001 and rdata=0xA5 at E+2; busy high for exactly 2 cycles.
2. Write then read. Requester 1 writes 0x3C to 0x20; after its ack, requester 1 reads 0x20.
   -> mem_we=1 only in the first ACCESS; second ack returns rdata=0x3C.
3. All three request from reset (req=111, held until each ack).
   -> grant order 001, 010, 100; acks 3 cycles apart; a 4th access by requester 0, if it re-requests, follows.
4. Rotation. After requester 1 is served (rr_ptr=1), req=101 simultaneously.
   -> requester 2 granted first, then requester 0.
5. Reset mid-access. Assert rst during ACCESS of a read by requester 0.
   -> all outputs 0 immediately (asynchronously), no ack, state IDLE.
   -> After release, req=001 is served first (rr_ptr=2).
6. Continuous requesters 0 and 1, plus requester 2 holding req with we=1 while addr2 changes mid-access.
   -> strict alternation among requesters; the write uses the address latched at grant; no ack overlaps.
